// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and frame-length helper for the UART message streamer
package uart_pkg;

   // Parity selection encoding
   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Byte sequencing / frame serialisation states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP
   } tx_state_t;

   // Number of bit periods in one frame: start + data + optional parity + stop
   function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
      return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - single-frame UART serialiser with load/start handshake and end-of-frame strobe
module uart_frame_tx
   import uart_pkg::*;
#(
   parameter int CLK_DIV   = 87,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = PAR_NONE,
   parameter int STOP_BITS = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic                 i_more,
   input  logic [DATA_BITS-1:0] i_data,
   output logic                 o_done,
   output logic                 o_txd
);

   localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
   localparam int CW         = $clog2(CLK_DIV);
   localparam int BW         = $clog2(FRAME_BITS);

   localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS);
   localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);

   tx_state_t              r_state;
   logic [CW-1:0]          r_cnt;
   logic [BW-1:0]          r_bit;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_par;
   logic                   r_txd;

   logic                   w_bit_end;
   logic [DATA_BITS-1:0]   w_shift_next;

   // r_bit holds the position within the frame: 0 = start, 1..DATA_BITS = data, then parity/stop
   assign w_bit_end    = (r_cnt == DIV_LAST);
   assign w_shift_next = r_shift >> 1;
   assign o_done       = (r_state == ST_STOP) && w_bit_end && (r_bit == LAST_BIT);
   assign o_txd        = r_txd;

   // Frame FSM: LOAD captures the byte, then each bit is held for CLK_DIV cycles
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_txd   <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_txd <= 1'b1;
               if (i_start) r_state <= ST_LOAD;
            end
            ST_LOAD: begin
               r_shift <= i_data;
               r_par   <= (PARITY == PAR_ODD) ? ~^i_data : ^i_data;
               r_txd   <= 1'b0;
               r_cnt   <= '0;
               r_bit   <= '0;
               r_state <= ST_START;
            end
            ST_START: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_bit   <= r_bit + 1'b1;
                  r_txd   <= r_shift[0];
                  r_state <= ST_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  r_bit <= r_bit + 1'b1;
                  if (r_bit == LAST_DATA) begin
                     if (PARITY != PAR_NONE) begin
                        r_txd   <= r_par;
                        r_state <= ST_PAR;
                     end else begin
                        r_txd   <= 1'b1;
                        r_state <= ST_STOP;
                     end
                  end else begin
                     r_shift <= w_shift_next;
                     r_txd   <= w_shift_next[0];
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_PAR: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_bit   <= r_bit + 1'b1;
                  r_txd   <= 1'b1;
                  r_state <= ST_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_bit == LAST_BIT) begin
                     r_bit   <= '0;
                     r_state <= i_more ? ST_LOAD : ST_IDLE;
                  end else begin
                     r_bit <= r_bit + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_msg_streamer.sv
// rtl/uart_msg_streamer.sv - message buffer, period timer and byte sequencer feeding a UART frame serialiser
module uart_msg_streamer
   import uart_pkg::*;
#(
   parameter int CLK_DIV   = 87,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = PAR_NONE,
   parameter int STOP_BITS = 1,
   parameter int MSG_DEPTH = 16,
   parameter int PERIOD    = 10000000,
   localparam int AW       = $clog2(MSG_DEPTH)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_enable,
   input  logic                 i_trigger,
   input  logic [AW:0]          i_msg_len,
   input  logic                 i_wr_en,
   input  logic [AW-1:0]        i_wr_addr,
   input  logic [DATA_BITS-1:0] i_wr_data,
   output logic                 o_txd,
   output logic                 o_busy,
   output logic                 o_byte_done,
   output logic                 o_msg_done,
   output logic [AW-1:0]        o_byte_idx
);

   localparam int            PW        = $clog2(PERIOD);
   localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD - 1);
   localparam logic [AW:0]   DEPTH_LEN = (AW + 1)'(MSG_DEPTH);

   logic [DATA_BITS-1:0] r_mem [MSG_DEPTH];
   logic [PW-1:0]        r_per;
   logic                 r_busy;
   logic [AW-1:0]        r_idx;
   logic [AW:0]          r_len;
   logic                 r_byte_done;
   logic                 r_msg_done;

   logic                 w_tick;
   logic [AW:0]          w_len;
   logic                 w_accept;
   logic                 w_last;
   logic                 w_frame_done;
   logic [DATA_BITS-1:0] w_rd_data;

   assign w_tick    = i_enable && (r_per == PER_LAST);
   assign w_len     = (i_msg_len > DEPTH_LEN) ? DEPTH_LEN : i_msg_len;
   assign w_accept  = !r_busy && (w_tick || i_trigger) && (w_len != '0);
   assign w_last    = ({1'b0, r_idx} == (r_len - 1'b1));
   // Combinational read: a same-cycle write lands after this value is captured, so LOAD sees old data
   assign w_rd_data = r_mem[r_idx];

   assign o_busy      = r_busy;
   assign o_byte_done = r_byte_done;
   assign o_msg_done  = r_msg_done;
   assign o_byte_idx  = r_idx;

   // Message buffer write port; contents deliberately survive reset
   always_ff @(posedge i_clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   // Free-running period timer, parked at zero while periodic mode is off
   always_ff @(posedge i_clk) begin
      if (i_rst || !i_enable) begin
         r_per <= '0;
      end else if (r_per == PER_LAST) begin
         r_per <= '0;
      end else begin
         r_per <= r_per + 1'b1;
      end
   end

   // Byte sequencer: accept a start only when idle, step through bytes on each frame end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy      <= 1'b0;
         r_idx       <= '0;
         r_len       <= '0;
         r_byte_done <= 1'b0;
         r_msg_done  <= 1'b0;
      end else begin
         r_byte_done <= 1'b0;
         r_msg_done  <= 1'b0;
         if (w_accept) begin
            r_busy <= 1'b1;
            r_len  <= w_len;
            r_idx  <= '0;
         end else if (r_busy && w_frame_done) begin
            r_byte_done <= 1'b1;
            if (w_last) begin
               r_msg_done <= 1'b1;
               r_busy     <= 1'b0;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end
      end
   end

   uart_frame_tx #(
      .CLK_DIV  (CLK_DIV),
      .DATA_BITS(DATA_BITS),
      .PARITY   (PARITY),
      .STOP_BITS(STOP_BITS)
   ) u_frame_tx (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_start(w_accept),
      .i_more (!w_last),
      .i_data (w_rd_data),
      .o_done (w_frame_done),
      .o_txd  (o_txd)
   );

endmodule
